// File: rtl/dac_seq_pkg.sv
// Shared types for the DAC sweep sequencer: FSM states, channel ids, output bundle.
// Pure declarations; no logic, no latency.
// No flow control.
package dac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        SWEEP = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam logic [1:0] CH_R    = 2'd0;
    localparam logic [1:0] CH_G    = 2'd1;
    localparam logic [1:0] CH_B    = 2'd2;
    localparam logic [1:0] CH_NONE = 2'd3;

    localparam int CODE_MAX = 255;

    // Everything the DAC side sees, registered together as one bundle.
    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
        logic [2:0] bias;
        logic [1:0] chan;
        logic       sample;
        logic       busy;
        logic       done;
    } dac_out_t;

    function automatic logic [7:0] chan_code(input logic [1:0] sel,
                                             input logic [1:0] active_ch,
                                             input logic [7:0] code);
        return (sel == active_ch) ? code : 8'd0;
    endfunction

endpackage

// File: rtl/dac_sweep_counter.sv
// Sweep position counters (dwell, code, channel, bias) with freeze on blanking.
// Flags are combinational from the current count; counts update on the next edge.
// Stalls (holds all counts) whenever i_run or i_active is low.
module dac_sweep_counter
    import dac_seq_pkg::*;
#(
    parameter int DWELL_W    = 8,
    parameter int BIAS_FIRST = 0,
    parameter int BIAS_LAST  = 7,
    parameter int CODE_STEP  = 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_init,
    input  logic               i_run,
    input  logic               i_active,
    input  logic [DWELL_W-1:0] i_dwell,
    output logic [7:0]         o_code,
    output logic [1:0]         o_chan,
    output logic [2:0]         o_bias_idx,
    output logic               o_sample,
    output logic               o_last_step
);

    localparam logic [8:0] STEP9     = 9'(CODE_STEP);
    localparam logic [8:0] CODE_MAX9 = 9'(CODE_MAX);
    localparam logic [2:0] BIAS_F3   = 3'(BIAS_FIRST);
    localparam logic [2:0] BIAS_L3   = 3'(BIAS_LAST);

    logic [DWELL_W-1:0] r_dcnt;
    logic [7:0]         r_code;
    logic [1:0]         r_chan;
    logic [2:0]         r_bias_idx;

    logic [DWELL_W-1:0] w_dwell_last;
    logic [8:0]         w_sum;
    logic               w_step;
    logic               w_dwell_end;
    logic               w_chan_end;
    logic               w_bias_end;

    // A dwell of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign w_dwell_last = (i_dwell == '0) ? '0 : i_dwell - DWELL_W'(1);
    assign w_sum        = {1'b0, r_code} + STEP9;
    assign w_step       = i_run && i_active;
    assign w_dwell_end  = w_step && (r_dcnt == w_dwell_last);
    assign w_chan_end   = w_dwell_end && (w_sum > CODE_MAX9);
    assign w_bias_end   = w_chan_end && (r_chan == CH_B);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_dcnt     <= '0;
            r_code     <= '0;
            r_chan     <= CH_R;
            r_bias_idx <= '0;
        end else if (i_init) begin
            r_dcnt     <= '0;
            r_code     <= '0;
            r_chan     <= CH_R;
            r_bias_idx <= BIAS_F3;
        end else if (w_step) begin
            if (w_dwell_end) begin
                r_dcnt <= '0;
                // Ramp never wraps: overflow past 255 hands over to the next channel.
                if (w_chan_end) begin
                    r_code <= '0;
                    if (r_chan == CH_B) begin
                        r_chan     <= CH_R;
                        r_bias_idx <= r_bias_idx + 3'd1;
                    end else begin
                        r_chan <= r_chan + 2'd1;
                    end
                end else begin
                    r_code <= w_sum[7:0];
                end
            end else begin
                r_dcnt <= r_dcnt + DWELL_W'(1);
            end
        end
    end

    assign o_code      = r_code;
    assign o_chan      = r_chan;
    assign o_bias_idx  = r_bias_idx;
    assign o_sample    = w_dwell_end;
    assign o_last_step = w_bias_end && (r_bias_idx == BIAS_L3);

endmodule

// File: rtl/dac_sweep_sequencer.sv
// Owns the RGB DAC buses and bias: pixel pass-through, or a frame-synced code sweep.
// All DAC-side outputs are registered: one cycle after the state/input that causes them.
// No backpressure; blanking stalls the sweep, abort/rst cancel it immediately.
module dac_sweep_sequencer
    import dac_seq_pkg::*;
#(
    parameter int DWELL_W    = 8,
    parameter int BIAS_FIRST = 0,
    parameter int BIAS_LAST  = 7,
    parameter int CODE_STEP  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [7:0]         pix_r,
    input  logic [7:0]         pix_g,
    input  logic [7:0]         pix_b,
    input  logic [2:0]         bias_in,
    input  logic               hblank,
    input  logic               vblank,
    output logic [7:0]         R,
    output logic [7:0]         G,
    output logic [7:0]         B,
    output logic [2:0]         bias,
    output logic [1:0]         chan,
    output logic               sample,
    output logic               busy,
    output logic               done
);

    seq_state_t         r_state;
    seq_state_t         w_state_nxt;
    logic [DWELL_W-1:0] r_dwell_q;
    logic               r_vblank_d;
    dac_out_t           r_out;
    dac_out_t           w_out_nxt;

    logic               w_vblank_rise;
    logic               w_active;
    logic               w_init;
    logic               w_run;
    logic               w_sample;
    logic               w_last_step;
    logic [7:0]         w_code;
    logic [1:0]         w_chan;
    logic [2:0]         w_bias_idx;

    assign w_vblank_rise = vblank && !r_vblank_d;
    assign w_active      = !hblank && !vblank;
    assign w_run         = (r_state == SWEEP);

    dac_sweep_counter #(
        .DWELL_W    (DWELL_W),
        .BIAS_FIRST (BIAS_FIRST),
        .BIAS_LAST  (BIAS_LAST),
        .CODE_STEP  (CODE_STEP)
    ) u_counter (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_init      (w_init),
        .i_run       (w_run),
        .i_active    (w_active),
        .i_dwell     (r_dwell_q),
        .o_code      (w_code),
        .o_chan      (w_chan),
        .o_bias_idx  (w_bias_idx),
        .o_sample    (w_sample),
        .o_last_step (w_last_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_dwell_q  <= '0;
            r_vblank_d <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_vblank_d <= vblank;
            if (r_state == IDLE && start && !abort) begin
                r_dwell_q <= dwell;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !abort) begin
                    w_state_nxt = ARM;
                end
            end
            ARM: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_vblank_rise) begin
                    w_state_nxt = SWEEP;
                    w_init      = 1'b1;
                end
            end
            SWEEP: begin
                if (abort) begin
                    w_state_nxt = IDLE;
                end else if (w_last_step) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Abort overrides the current state so the DACs are handed back on the very next edge.
    always_comb begin
        w_out_nxt.r      = pix_r;
        w_out_nxt.g      = pix_g;
        w_out_nxt.b      = pix_b;
        w_out_nxt.bias   = bias_in;
        w_out_nxt.chan   = CH_NONE;
        w_out_nxt.sample = 1'b0;
        w_out_nxt.busy   = (r_state != IDLE) && !abort;
        w_out_nxt.done   = (r_state == DONE) && !abort;
        if (r_state == SWEEP && !abort) begin
            w_out_nxt.r      = w_active ? chan_code(CH_R, w_chan, w_code) : 8'd0;
            w_out_nxt.g      = w_active ? chan_code(CH_G, w_chan, w_code) : 8'd0;
            w_out_nxt.b      = w_active ? chan_code(CH_B, w_chan, w_code) : 8'd0;
            w_out_nxt.bias   = w_bias_idx;
            w_out_nxt.chan   = w_chan;
            w_out_nxt.sample = w_sample;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out      <= '0;
            r_out.chan <= CH_NONE;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign R      = r_out.r;
    assign G      = r_out.g;
    assign B      = r_out.b;
    assign bias   = r_out.bias;
    assign chan   = r_out.chan;
    assign sample = r_out.sample;
    assign busy   = r_out.busy;
    assign done   = r_out.done;

endmodule

// File: tb/tb_dac_sweep_sequencer.sv
// Directed bench for dac_sweep_sequencer: pass-through, sweep ramp, blank freeze,
// arming, abort/reset, dwell=0 and CODE_STEP=1 channel hand-over.
module tb_dac_sweep_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, start_s1, abort, hblank, vblank;
    logic [7:0] dwell, pix_r, pix_g, pix_b;
    logic [2:0] bias_in;

    logic [7:0] R, G, B;
    logic [2:0] bias;
    logic [1:0] chan;
    logic       sample, busy, done;

    logic [7:0] R1, G1, B1;
    logic [2:0] bias1;
    logic [1:0] chan1;
    logic       sample1, busy1, done1;

    int n_checks = 0;
    int n_errors = 0;

    dac_sweep_sequencer #(
        .DWELL_W(8), .BIAS_FIRST(2), .BIAS_LAST(2), .CODE_STEP(64)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell(dwell),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .bias_in(bias_in),
        .hblank(hblank), .vblank(vblank),
        .R(R), .G(G), .B(B), .bias(bias), .chan(chan),
        .sample(sample), .busy(busy), .done(done)
    );

    dac_sweep_sequencer #(
        .DWELL_W(8), .BIAS_FIRST(0), .BIAS_LAST(0), .CODE_STEP(1)
    ) u_dut_s1 (
        .clk(clk), .rst(rst), .start(start_s1), .abort(abort), .dwell(dwell),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b), .bias_in(bias_in),
        .hblank(hblank), .vblank(vblank),
        .R(R1), .G(G1), .B(B1), .bias(bias1), .chan(chan1),
        .sample(sample1), .busy(busy1), .done(done1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] vec(input logic [7:0] r, input logic [7:0] g,
                                        input logic [7:0] b, input logic [2:0] bi,
                                        input logic [1:0] ch, input logic smp,
                                        input logic bsy, input logic dn);
        return {r, g, b, bi, ch, smp, bsy, dn};
    endfunction

    function automatic logic [31:0] dut_vec();
        return {R, G, B, bias, chan, sample, busy, done};
    endfunction

    // Expected output k active cycles into a sweep of the main DUT (bias 2, step 64).
    function automatic logic [31:0] sweep_exp(input int k, input int dw);
        int         ch;
        int         code;
        logic [7:0] c8;
        logic [1:0] ch2;
        ch   = k / (4 * dw);
        code = ((k % (4 * dw)) / dw) * 64;
        c8   = 8'(code);
        ch2  = 2'(ch);
        return vec((ch == 0) ? c8 : 8'd0, (ch == 1) ? c8 : 8'd0, (ch == 2) ? c8 : 8'd0,
                   3'd2, ch2, (k % dw) == dw - 1, 1'b1, 1'b0);
    endfunction

    logic [31:0] idle_view;
    logic [31:0] arm_view;
    int          n_sample;
    int          n_done;

    initial begin
        rst = 1'b1; start = 1'b0; start_s1 = 1'b0; abort = 1'b0;
        hblank = 1'b0; vblank = 1'b0; dwell = 8'd3;
        pix_r = 8'h12; pix_g = 8'h34; pix_b = 8'h56; bias_in = 3'd5;
        tick(); tick();
        chk("reset_out", dut_vec(), vec(8'h00, 8'h00, 8'h00, 3'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        chk("reset_s1_chan", {30'd0, chan1}, 32'd3);

        // Pass-through
        rst = 1'b0;
        tick();
        chk("pass_thru", dut_vec(), vec(8'h12, 8'h34, 8'h56, 3'd5, 2'd3, 1'b0, 1'b0, 1'b0));
        pix_r = 8'hAB; bias_in = 3'd1;
        #2;
        chk("pass_latency", {24'd0, R}, 32'h12);
        tick();
        idle_view = vec(8'hAB, 8'h34, 8'h56, 3'd1, 2'd3, 1'b0, 1'b0, 1'b0);
        arm_view  = vec(8'hAB, 8'h34, 8'h56, 3'd1, 2'd3, 1'b0, 1'b1, 1'b0);
        chk("pass_thru2", dut_vec(), idle_view);

        // Full sweep, dwell 3; dwell changed after capture must not matter
        start = 1'b1;
        tick();
        start = 1'b0; dwell = 8'd7;
        chk("start_idle_view", dut_vec(), idle_view);
        tick();
        chk("arm_view", dut_vec(), arm_view);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        n_sample = 0; n_done = 0;
        for (int k = 0; k < 36; k++) begin
            tick();
            chk($sformatf("sweep_k%0d", k), dut_vec(), sweep_exp(k, 3));
            if (sample) n_sample++;
            if (done) n_done++;
        end
        chk("sample_count", n_sample, 12);
        chk("done_during_sweep", n_done, 0);
        tick();
        chk("done_pulse", dut_vec(), vec(8'hAB, 8'h34, 8'h56, 3'd1, 2'd3, 1'b0, 1'b1, 1'b1));
        tick();
        chk("after_done", dut_vec(), idle_view);

        // Blank freeze at R=64, dcnt=1, then abort
        dwell = 8'd3; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("pre_blank_k%0d", k), dut_vec(), sweep_exp(k, 3));
        end
        hblank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("blank_%0d", i), dut_vec(), vec(8'h00, 8'h00, 8'h00, 3'd2, 2'd0, 1'b0, 1'b1, 1'b0));
        end
        hblank = 1'b0;
        for (int k = 4; k < 9; k++) begin
            tick();
            chk($sformatf("post_blank_k%0d", k), dut_vec(), sweep_exp(k, 3));
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_pass", dut_vec(), idle_view);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("abort_idle_%0d", i), dut_vec(), idle_view);
        end

        // start and abort together in IDLE: stay idle
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        tick();
        chk("start_abort_idle", dut_vec(), idle_view);

        // Arming with vblank already high: needs a fresh rising edge
        vblank = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("arm_vbhigh_%0d", i), dut_vec(), arm_view);
        end
        vblank = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("arm_vblow_%0d", i), dut_vec(), arm_view);
        end
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("arm_sweep_k%0d", k), dut_vec(), sweep_exp(k, 3));
        end
        start = 1'b1; dwell = 8'd5;
        tick();
        start = 1'b0;
        chk("start_in_sweep_k3", dut_vec(), sweep_exp(3, 3));
        for (int k = 4; k < 7; k++) begin
            tick();
            chk($sformatf("start_ignored_k%0d", k), dut_vec(), sweep_exp(k, 3));
        end

        // Reset mid-sweep
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid", dut_vec(), vec(8'h00, 8'h00, 8'h00, 3'd0, 2'd3, 1'b0, 1'b0, 1'b0));
        tick();
        chk("rst_then_pass", dut_vec(), idle_view);

        // dwell = 0 behaves as 1
        dwell = 8'd0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("dw0_k%0d", k), dut_vec(), sweep_exp(k, 1));
        end
        tick();
        chk("dw0_done", dut_vec(), vec(8'hAB, 8'h34, 8'h56, 3'd1, 2'd3, 1'b0, 1'b1, 1'b1));
        tick();
        chk("dw0_idle", dut_vec(), idle_view);

        // CODE_STEP = 1: ramp reaches 255 then hands over without wrapping
        start_s1 = 1'b1;
        tick();
        start_s1 = 1'b0;
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        for (int k = 0; k < 770; k++) begin
            tick();
            if (k == 0)   chk("s1_k0", {14'd0, R1, G1, chan1}, {14'd0, 8'd0, 8'd0, 2'd0});
            if (k == 1)   chk("s1_k1", {24'd0, R1}, 32'd1);
            if (k == 254) chk("s1_k254", {24'd0, R1}, 32'd254);
            if (k == 255) chk("s1_k255", {14'd0, R1, G1, chan1}, {14'd0, 8'd255, 8'd0, 2'd0});
            if (k == 256) chk("s1_k256", {14'd0, R1, G1, chan1}, {14'd0, 8'd0, 8'd0, 2'd1});
            if (k == 257) chk("s1_k257", {14'd0, R1, G1, chan1}, {14'd0, 8'd0, 8'd1, 2'd1});
            if (k == 767) chk("s1_k767", {14'd0, B1, G1, chan1}, {14'd0, 8'd255, 8'd0, 2'd2});
            if (k == 768) chk("s1_done", {29'd0, chan1, done1}, {29'd0, 2'd3, 1'b1});
            if (k == 769) chk("s1_idle", {30'd0, busy1, done1}, 32'd0);
        end
        chk("main_idle_during_s1", dut_vec(), idle_view);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dac_sweep_sequencer.md
Name: dac_sweep_sequencer

Overview:
- Frame-synchronous scheduler that owns the R/G/B DAC input buses and the shared 3-bit bias control.
- Normal mode: registered pass-through of the pattern generator's RGB888 and the external bias code.
- Sweep mode: on a start request it takes over the DACs. For each bias code and each channel (R, G, then B) it steps that channel through a code ramp, holding each code for a programmable dwell, and pulses a sample strobe for external measurement.
- Sits between the VGA pattern controller (pixels, hblank, vblank) and the DAC inputs.

Parameters:
- DWELL_W, 8, width of the dwell-count input.
- BIAS_FIRST, 0, first bias code swept (3-bit).
- BIAS_LAST, 7, last bias code swept (3-bit), BIAS_LAST >= BIAS_FIRST.
- CODE_STEP, 1, ramp increment (1..255).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  sweep request pulse; honoured only in IDLE.
- abort  in  1  cancels any sweep.
- dwell  in  DWELL_W  cycles per code; captured at start; 0 is treated as 1.
- pix_r, pix_g, pix_b  in  8 each  pattern-generator colour channels.
- bias_in  in  3  external bias code.
- hblank, vblank  in  1 each  blanking flags from the pattern controller.
- R, G, B  out  8 each  DAC channel codes (registered).
- bias  out  3  DAC bias code, common to all channels (registered).
- chan  out  2  active sweep channel: 0=R, 1=G, 2=B, 3=none.
- sample  out  1  one-cycle strobe on the last cycle of each dwell.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a full sweep completes.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; R=G=B=0; bias=0; chan=3; sample=0; busy=0; done=0; all counters 0. Reset mid-sweep aborts with no done pulse.
- IDLE:
  - R/G/B = pix_r/g/b and bias = bias_in, with 1-cycle latency.
  - start=1 captures dwell into dwell_q; next state is ARM.
- ARM:
  - Outputs hold pass-through.
  - Waits for a vblank rising edge, detected against a registered vblank. On that edge, next state is SWEEP, with bias_idx=BIAS_FIRST, chan=0, code=0, dcnt=0.
- SWEEP, per clk:
  - Outputs: the selected channel carries code; the other two carry 0; bias = bias_idx.
  - Active only when hblank=0 and vblank=0. Otherwise all channels are forced to 0, and dcnt, code, chan and bias_idx freeze.
  - Active cycle: dcnt increments. When dcnt == max(dwell_q,1)-1: sample=1 for that cycle, dcnt clears, and code advances by CODE_STEP.
  - Code advance uses a 9-bit sum. If the sum > 255, the channel ends: code=0 and chan advances. There is no wrap.
  - After chan 2 ends, chan returns to 0 and bias_idx increments. After bias_idx == BIAS_LAST ends, next state is DONE.
- DONE: lasts one cycle with done=1 and chan=3. The next state is IDLE.
- abort=1 in ARM, SWEEP or DONE: next state is IDLE, with no done pulse. Pass-through resumes on the following cycle.
- Priority: rst > abort > start. start in a non-IDLE state is ignored. start and abort asserted together in IDLE: stay in IDLE.
- Sweep length in active cycles = (BIAS_LAST-BIAS_FIRST+1) * 3 * ceil(256/CODE_STEP) * max(dwell,1).
- Registered-output rule: an R/G/B/bias/chan/sample value caused by a state or counter change appears on the clk edge after that change.

Decomposition:
- Package dac_seq_pkg:
  - State enum {IDLE, ARM, SWEEP, DONE}.
  - Channel constants CH_R=0, CH_G=1, CH_B=2, CH_NONE=3.
  - CODE_MAX=255.
- One natural sub-module: dac_sweep_counter. It holds dcnt, code, chan and bias_idx with the freeze-on-blank and carry/terminal logic, and exports sample plus a last_step flag to the FSM.

Test Plan:
- Pass-through: rst, then pix_r=0x12, pix_g=0x34, pix_b=0x56, bias_in=5 → R/G/B=12/34/56 and bias=5 one cycle later; busy=0, chan=3.
- Sweep sequencing: BIAS_FIRST=BIAS_LAST=2, CODE_STEP=64, dwell=3, blanks held low after the vblank edge. Expect:
  - R ramps 0, 64, 128, 192, each code held for 3 cycles, then G, then B;
  - sample fires 12 times; bias=2 throughout;
  - done pulses exactly once after 36 active cycles; busy then drops.
- Blank freeze: mid-ramp with R=64, dcnt=1, assert hblank for 10 cycles → R=G=B=0 during the blank; after the blank, R=64 resumes with exactly 2 cycles remaining in that dwell.
- Arming: start while vblank is already high → no sweep until vblank falls and rises again. start during SWEEP → ignored.
- Boundary: dwell=0 → each code lasts 1 cycle. CODE_STEP=1 → code reaches 255, and the channel then advances, with no wrap to 0 on the same channel.
- Abort/reset: abort in SWEEP → pass-through the next cycle, done never asserted, chan=3. rst mid-sweep → all outputs 0 next cycle.
